// File: rtl/sigmoid_pkg.sv
// Shared types and PLAN approximation constants for the sigmoid pipeline.
package sigmoid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int G = 5;

    // Segment slopes and offsets, lowest |x| segment first; offsets are scaled by FRAC_BITS at use.
    localparam int SLOPE_LO  = 8;
    localparam int SLOPE_MID = 4;
    localparam int SLOPE_HI  = 1;
    localparam int OFFS_LO   = 16;
    localparam int OFFS_MID  = 20;
    localparam int OFFS_HI   = 27;

    function automatic int bp_one(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    function automatic int bp_knee(input int frac_bits);
        return (19 << frac_bits) >> 3;
    endfunction

    function automatic int bp_sat(input int frac_bits);
        return 5 << frac_bits;
    endfunction

endpackage

// File: rtl/sigmoid_plan_lane.sv
// One combinational PLAN sigmoid channel: signed fixed-point x in, y in [0, 1.0] out.
module sigmoid_plan_lane
    import sigmoid_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic [DATA_SIZE-1:0] x,
    output logic [DATA_SIZE-1:0] y
);

    localparam int AW = DATA_SIZE + 1;
    localparam int CW = DATA_SIZE + 6;

    localparam logic [AW-1:0]        A_ONE   = AW'(1);
    localparam logic [CW-1:0]        BP_ONE  = CW'(bp_one(FRAC_BITS));
    localparam logic [CW-1:0]        BP_KNEE = CW'(bp_knee(FRAC_BITS));
    localparam logic [CW-1:0]        BP_SAT  = CW'(bp_sat(FRAC_BITS));
    localparam logic [DATA_SIZE-1:0] Y_ONE   = DATA_SIZE'(bp_one(FRAC_BITS));

    logic                 neg;
    logic [AW-1:0]        sx;
    logic [AW-1:0]        a;
    logic [CW-1:0]        a_w;
    logic [CW-1:0]        slope;
    logic [CW-1:0]        offs;
    logic [CW-1:0]        sum;
    logic [DATA_SIZE-1:0] p;

    always_comb begin
        neg = x[DATA_SIZE-1];
        // One extra bit so negating the most-negative input cannot overflow.
        sx  = {x[DATA_SIZE-1], x};
        a   = neg ? (~sx + A_ONE) : sx;
        a_w = CW'(a);

        slope = CW'(SLOPE_LO);
        offs  = CW'(OFFS_LO << FRAC_BITS);
        if (a_w >= BP_KNEE) begin
            slope = CW'(SLOPE_HI);
            offs  = CW'(OFFS_HI << FRAC_BITS);
        end else if (a_w >= BP_ONE) begin
            slope = CW'(SLOPE_MID);
            offs  = CW'(OFFS_MID << FRAC_BITS);
        end

        sum = a_w * slope + offs;
        p   = (a_w >= BP_SAT) ? Y_ONE : DATA_SIZE'(sum >> G);
        y   = neg ? (Y_ONE - p) : p;
    end

endmodule

// File: rtl/sigmoid_pipe.sv
// Vector sigmoid stage: LANES PLAN lanes time-shared over SIZE channels, valid/ready on both sides.
// Optional raw pass-through for linear layers when SIGMOID_BYPASS_EN is defined.
//
// state | meaning
// IDLE  | in_ready high, waiting for an input vector
// CALC  | computing LANES channels per cycle, beat selects the slice
// DONE  | result held on output_stream until out_ready
module sigmoid_pipe
    import sigmoid_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int FRAC_BITS = 4,
    parameter int SIZE      = 4,
    parameter int LANES     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_SIZE*SIZE-1:0] input_stream,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_SIZE*SIZE-1:0] output_stream,
    output logic                      out_valid,
`ifdef SIGMOID_BYPASS_EN
    input  logic                      bypass,
`endif
    input  logic                      out_ready
);

    localparam int BEATS = SIZE / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    state_t                    state;
    state_t                    state_d;
    logic [BW-1:0]             beat;
    logic [DATA_SIZE*SIZE-1:0] buf_q;
    logic [DATA_SIZE*SIZE-1:0] out_q;
    logic                      out_valid_q;
    logic                      accept;
    logic                      last_beat;

    logic [DATA_SIZE-1:0] lane_x   [LANES];
    logic [DATA_SIZE-1:0] lane_y   [LANES];
    logic [DATA_SIZE-1:0] lane_out [LANES];

`ifdef SIGMOID_BYPASS_EN
    logic byp_q;
`endif

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        last_beat = (beat == BEAT_LAST);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_beat) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pick this beat's slice of the buffer for each lane.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_x[l] = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (beat == BW'(b)) lane_x[l] = buf_q[(b*LANES + l)*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sigmoid_plan_lane #(
            .DATA_SIZE (DATA_SIZE),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .x (lane_x[g]),
            .y (lane_y[g])
        );
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
`ifdef SIGMOID_BYPASS_EN
            lane_out[l] = byp_q ? lane_x[l] : lane_y[l];
`else
            lane_out[l] = lane_y[l];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat        <= '0;
            buf_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef SIGMOID_BYPASS_EN
            byp_q       <= 1'b0;
`endif
        end else begin
            state <= state_d;
            if (accept) begin
                buf_q <= input_stream;
                beat  <= '0;
`ifdef SIGMOID_BYPASS_EN
                byp_q <= bypass;
`endif
            end
            if (state == CALC) begin
                for (int b = 0; b < BEATS; b++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (beat == BW'(b)) out_q[(b*LANES + l)*DATA_SIZE +: DATA_SIZE] <= lane_out[l];
                    end
                end
                beat <= last_beat ? '0 : beat + BEAT_ONE;
            end
            if (state == CALC && last_beat) begin
                out_valid_q <= 1'b1;
            end else if (state == DONE && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready      = (state == IDLE) && !reset;
    assign out_valid     = out_valid_q;
    assign output_stream = out_q;

endmodule

// File: doc/sigmoid_pipe.md
Name: sigmoid_pipe

Overview:
- Fixed-point sigmoid activation over a vector of SIZE channels, using a PLAN piecewise-linear approximation.
- Time-multiplexes LANES combinational lanes across the vector under an FSM, with valid/ready handshakes on both sides.
- Sits between a neuron-layer accumulator output and the next layer's input buffer.
- Generalised successor of the pass-through sigmoid stage: adds real arithmetic, a parametrised lane count and flow control.

Parameters:
- DATA_SIZE, 8, bits per channel; two's-complement signed, FRAC_BITS fractional bits; must be >= FRAC_BITS+2.
- FRAC_BITS, 4, fractional bits of input and output.
- SIZE, 4, channels per vector.
- LANES, 2, channels computed per cycle; SIZE % LANES == 0; BEATS = SIZE/LANES.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- input_stream  input  DATA_SIZE*SIZE  channel i at bits [(i+1)*DATA_SIZE-1 : i*DATA_SIZE].
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- output_stream  output  DATA_SIZE*SIZE  result vector, same packing as input_stream.
- out_valid  output  1  output_stream holds a complete result.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- **Reset values**
  - state=IDLE, out_valid=0, output_stream=0, beat counter=0, input buffer=0.
  - in_ready=0 while reset is high.
- **States**
  - IDLE: in_ready=1. On in_valid&&in_ready, register input_stream into the buffer, beat=0, go CALC.
  - CALC: in_ready=0. Each cycle, compute channels beat*LANES .. beat*LANES+LANES-1 from the buffer and register them into output_stream. Then beat++. At beat==BEATS-1, go DONE and set out_valid=1 on the same edge.
  - DONE: out_valid=1; output_stream stays stable. On out_ready, clear out_valid and go IDLE.
- **Timing**
  - Latency: acceptance at edge k; out_valid high after edge k+BEATS.
  - Minimum period: BEATS+2 cycles per vector.
  - in_valid in CALC/DONE is ignored; input_stream is sampled only at acceptance.
- **Arithmetic, per channel** (G=5 guard bits; let x = signed input, a = |x| held in DATA_SIZE+1 bits so the most-negative value is safe):
  - a >= 5.0 (5<<F): p = 1<<F.
  - a >= 2.375 (38 for F=4; generally (19<<F)>>3): p = (a*1 + (27<<F)) >> G.
  - a >= 1.0: p = (a*4 + (20<<F)) >> G.
  - else: p = (a*8 + (16<<F)) >> G.
  - Right shifts truncate (floor).
  - Result: y = p for x>=0; y = (1<<F) - p for x<0.
  - y is always in [0, 1<<F]; upper bits are zero-extended to DATA_SIZE.
- **Boundaries**
  - Reset asserted mid-CALC or in DONE aborts to the reset state; the partial result is discarded.
  - out_ready high in IDLE/CALC has no effect.
  - LANES==SIZE gives BEATS=1: one CALC cycle.

Optional Feature:
- Macro SIGMOID_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit), sampled with the vector at acceptance.
  - If it was 1, each lane writes the raw input channel instead of the sigmoid, with identical latency and handshakes.
  - Used for linear output layers.
- When undefined: the port is absent and the sigmoid path is always used.

Decomposition:
- Package sigmoid_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - guard-bit constant G=5;
  - slope constants 1, 4, 8;
  - offset constants 27, 20, 16;
  - breakpoint helper functions scaled by FRAC_BITS.
- Sub-module sigmoid_plan_lane: purely combinational, one channel (DATA_SIZE, FRAC_BITS in; y out). sigmoid_pipe instantiates LANES copies plus the FSM and buffers.

Test Plan:
All scenarios use defaults: F=4, SIZE=4, LANES=2, BEATS=2.
1. Inputs {0x00, 0x10, 0xF0, 0x50} (0, 1.0, -1.0, 5.0) -> out_valid 2 cycles after acceptance; outputs {0x08, 0x0C, 0x04, 0x10}.
2. Inputs {0x20, 0x30, 0xD0, 0x80} (2, 3, -3, -8) -> {0x0E, 0x0F, 0x01, 0x00}; most-negative input saturates cleanly.
3. out_ready held low 10 cycles in DONE -> output_stream and out_valid stable, in_ready=0, a new in_valid is ignored. Release -> IDLE next cycle; the next vector is accepted.
4. reset pulsed during the second CALC cycle -> next cycle out_valid=0, output_stream=0, state IDLE; no spurious out_valid later.
5. Back-to-back vectors with in_valid and out_ready tied high -> one result every 4 cycles, each matching the golden PLAN model.
6. With SIGMOID_BYPASS_EN defined and bypass=1, input {0x7F, 0x80, 0x01, 0xAA} -> identical output after 2 cycles; with bypass=0 -> scenario 1 results.
